ula_op_select_display: RTL

//  Sequential successor to the combinational ULA op-symbol decoder. Selects the ULA operation from

---
 rtl/ula_display_pkg.sv | 40 ++++
 rtl/ula_op_select_display_debouncer.sv | 37 +++
 rtl/ula_op_select_display.sv | 121 ++++++++++++
 3 files changed

// File: rtl/ula_display_pkg.sv
// Shared types, 7-segment glyph table and mnemonic lookup for the ULA op selector.
package ula_display_pkg;

   typedef enum logic {IDLE = 1'b0, EDIT = 1'b1} state_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Active-low letter codes, bit0 = segment a .. bit6 = segment g
   localparam logic [6:0] G_A = 7'h08;
   localparam logic [6:0] G_B = 7'h03;
   localparam logic [6:0] G_D = 7'h21;
   localparam logic [6:0] G_H = 7'h09;
   localparam logic [6:0] G_L = 7'h47;
   localparam logic [6:0] G_N = 7'h2B;
   localparam logic [6:0] G_O = 7'h40;
   localparam logic [6:0] G_R = 7'h2F;
   localparam logic [6:0] G_S = 7'h12;
   localparam logic [6:0] G_T = 7'h07;
   localparam logic [6:0] G_U = 7'h41;

   // [op][digit]; each row is written leftmost digit first, so mnemonics read right-aligned
   localparam logic [0:7][3:0][6:0] OP_GLYPHS = '{
      '{SEG_BLANK, G_A, G_D, G_D},        // ADD
      '{SEG_BLANK, G_S, G_U, G_B},        // SUB
      '{SEG_BLANK, G_A, G_N, G_D},        // AND
      '{SEG_BLANK, SEG_BLANK, G_O, G_R},  // OR
      '{SEG_BLANK, G_H, G_O, G_R},        // XOR
      '{SEG_BLANK, G_N, G_O, G_T},        // NOT
      '{SEG_BLANK, G_S, G_H, G_L},        // SHL
      '{SEG_BLANK, G_S, G_H, G_R}         // SHR
   };

   function automatic logic [27:0] op_to_hex(input logic [2:0] op, input int n_digits);
      logic [27:0] h;
      for (int i = 0; i < 4; i++)
         h[7*i +: 7] = (i < n_digits) ? OP_GLYPHS[op][i] : SEG_BLANK;
      return h;
   endfunction

endpackage

// File: rtl/ula_op_select_display_debouncer.sv
// Pushbutton conditioner: 2-flop synchronizer, stable-level counter, one-cycle press on debounced fall.
module key_debouncer #(
   parameter int DEBOUNCE_CYC = 500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key,
   output logic press
);

   localparam int CW = $clog2(DEBOUNCE_CYC + 1);

   logic [1:0]    sync;
   logic          level;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync  <= 2'b11;
         level <= 1'b1;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         sync  <= {sync[0], key};
         press <= 1'b0;
         if (sync[1] == level)
            cnt <= '0;
         else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
            level <= sync[1];
            cnt   <= '0;
            press <= ~sync[1];
         end else
            cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/ula_op_select_display.sv
// ULA opcode selector: button/switch select, committed opcode latch, blinking mnemonic display.
module ula_op_select_display
   import ula_display_pkg::*;
#(
   parameter  int N_OPS        = 8,
   parameter  int N_DIGITS     = 4,
   parameter  int DEBOUNCE_CYC = 500000,
   parameter  int BLINK_CYC    = 12500000,
   localparam int SEL_W        = (N_OPS > 1) ? $clog2(N_OPS) : 1
) (
   input  logic                  CLOCK_50,
   input  logic                  RESET_N,
   input  logic                  KEY_NEXT,
   input  logic                  KEY_CONFIRM,
   input  logic                  MODE,
   input  logic [SEL_W-1:0]      SW_SEL,
   output logic [SEL_W-1:0]      op_sel,
   output logic                  op_valid,
   output logic [7*N_DIGITS-1:0] HEX
);

   localparam int BW = $clog2(BLINK_CYC + 1);

   logic             next_press, confirm_press;
   state_t           state, state_nxt;
   logic [SEL_W-1:0] pending, pending_nxt, op_nxt;
   logic [SEL_W-1:0] sw_meta, sw_sync, sw_clamp, shown;
   logic [BW-1:0]    blink_cnt, blink_cnt_nxt;
   logic             visible, visible_nxt, restart, valid_nxt;
   logic [27:0]      glyphs;
   logic [7*N_DIGITS-1:0] hex_nxt;

   key_debouncer #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_next (
      .clk(CLOCK_50), .rst_n(RESET_N), .key(KEY_NEXT), .press(next_press)
   );

   key_debouncer #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_confirm (
      .clk(CLOCK_50), .rst_n(RESET_N), .key(KEY_CONFIRM), .press(confirm_press)
   );

   function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] v);
      return (v == SEL_W'(N_OPS - 1)) ? '0 : v + SEL_W'(1);
   endfunction

   // Widen before comparing: N_OPS itself may not fit in SEL_W bits
   assign sw_clamp = ({1'b0, sw_sync} >= (SEL_W + 1)'(N_OPS)) ? SEL_W'(N_OPS - 1) : sw_sync;

   always_comb begin
      state_nxt   = state;
      pending_nxt = pending;
      op_nxt      = op_sel;
      valid_nxt   = 1'b0;
      restart     = 1'b0;
      if (MODE) begin
         state_nxt = IDLE;
         op_nxt    = sw_clamp;
         valid_nxt = (sw_clamp != op_sel);
      end else begin
         case (state)
            IDLE: if (next_press) begin
               pending_nxt = wrap_inc(op_sel);
               state_nxt   = EDIT;
               restart     = 1'b1;
            end
            EDIT: if (confirm_press) begin
               op_nxt    = pending;
               valid_nxt = 1'b1;
               state_nxt = IDLE;
            end else if (next_press) begin
               pending_nxt = wrap_inc(pending);
               restart     = 1'b1;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      blink_cnt_nxt = blink_cnt + BW'(1);
      visible_nxt   = visible;
      if (state_nxt != EDIT || restart) begin
         blink_cnt_nxt = '0;
         visible_nxt   = 1'b1;
      end else if (blink_cnt == BW'(BLINK_CYC - 1)) begin
         blink_cnt_nxt = '0;
         visible_nxt   = ~visible;
      end
   end

   // Display is built from next-state values so HEX lands on the same edge as op_sel
   always_comb begin
      shown   = (state_nxt == EDIT) ? pending_nxt : op_nxt;
      glyphs  = op_to_hex(3'(shown), N_DIGITS);
      hex_nxt = visible_nxt ? glyphs[7*N_DIGITS-1:0] : {N_DIGITS{SEG_BLANK}};
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state     <= IDLE;
         pending   <= '0;
         op_sel    <= '0;
         op_valid  <= 1'b0;
         sw_meta   <= '0;
         sw_sync   <= '0;
         blink_cnt <= '0;
         visible   <= 1'b1;
         HEX       <= {N_DIGITS{SEG_BLANK}};
      end else begin
         sw_meta   <= SW_SEL;
         sw_sync   <= sw_meta;
         state     <= state_nxt;
         pending   <= pending_nxt;
         op_sel    <= op_nxt;
         op_valid  <= valid_nxt;
         blink_cnt <= blink_cnt_nxt;
         visible   <= visible_nxt;
         HEX       <= hex_nxt;
      end
   end

endmodule
